// File: rtl/cpu_error_capture_pkg.sv
// Shared definitions for the CPU error capture block: state encodings,
// error source bit positions and default sizing.
package cpu_error_capture_pkg;

  localparam int DEF_SRC_NUM     = 9;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_ACK_TIMEOUT = 255;

  // Level that rst_n takes when reset is active.
  localparam logic RST_ENABLE = 1'b0;

  // Bit positions of the error sources inside err_src_i.
  localparam int SRC_INST_CACHE = 0;
  localparam int SRC_DATA_CACHE = 1;
  localparam int SRC_IF         = 2;
  localparam int SRC_ID         = 3;
  localparam int SRC_LAUNCH     = 4;
  localparam int SRC_EX         = 5;
  localparam int SRC_MM         = 6;
  localparam int SRC_MEM        = 7;
  localparam int SRC_WB         = 8;

  typedef enum logic [1:0] {
    ERR_IDLE    = 2'b00,
    ERR_HALTING = 2'b01,
    ERR_HALTED  = 2'b10
  } err_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_error_capture_timeout.sv
// Loadable, clearable up-counter with a terminal-count flag; it measures
// how long the capture block has been waiting for the halt acknowledge.
module err_timeout_counter
  import cpu_error_capture_pkg::*;
#(
  parameter int            W    = 8,
  parameter logic [W-1:0]  TERM = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == TERM);

endmodule

// File: rtl/cpu_error_capture.sv
// Captures the first CPU error event (sources, cycle stamp, last committed
// PC), requests a pipeline halt and holds the capture until debug clears it.
module cpu_error_capture
  import cpu_error_capture_pkg::*;
#(
  parameter int SRC_NUM     = DEF_SRC_NUM,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_NUM-1:0] err_src_i,
  input  logic               commit_valid_i,
  input  logic [PC_W-1:0]    commit_pc_i,
  input  logic               halt_ack_i,
  input  logic               dbg_clear_i,
  output logic               halt_req_o,
  output logic               err_valid_o,
  output logic [SRC_NUM-1:0] err_first_src_o,
  output logic [SRC_NUM-1:0] err_all_src_o,
  output logic [CNT_W-1:0]   err_cycle_o,
  output logic [PC_W-1:0]    err_last_pc_o,
  output logic               err_timeout_o,
  output logic [7:0]         err_count_o,
  output logic [1:0]         state_o
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  err_state_e      state_q, state_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [PC_W-1:0]  last_pc_r;

  logic capture, clear, timeout_hit;
  logic to_en, to_clr, to_load, to_term;

  err_timeout_counter #(
    .W    (TO_W),
    .TERM (TO_W'(ACK_TIMEOUT - 1))
  ) u_to_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (to_clr),
    .load     (to_load),
    .load_val ('0),
    .en       (to_en),
    .term     (to_term)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    capture     = 1'b0;
    clear       = 1'b0;
    timeout_hit = 1'b0;
    to_en       = 1'b0;
    to_clr      = 1'b0;
    to_load     = 1'b0;
    unique case (state_q)
      ERR_IDLE: begin
        if (|err_src_i) begin
          capture   = 1'b1;
          to_load   = 1'b1;
          state_nxt = ERR_HALTING;
        end
      end
      ERR_HALTING: begin
        // An ack in the terminal cycle takes precedence over the timeout.
        if (halt_ack_i) begin
          state_nxt = ERR_HALTED;
        end else if (to_term) begin
          timeout_hit = 1'b1;
          state_nxt   = ERR_HALTED;
        end else begin
          to_en = 1'b1;
        end
      end
      ERR_HALTED: begin
        if (dbg_clear_i) begin
          clear     = 1'b1;
          to_clr    = 1'b1;
          state_nxt = ERR_IDLE;
        end
      end
      default: state_nxt = ERR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state_q    <= ERR_IDLE;
      halt_req_o <= 1'b0;
      cyc_cnt    <= '0;
      last_pc_r  <= '0;
    end else begin
      state_q    <= state_nxt;
      halt_req_o <= (state_nxt != ERR_IDLE);
      cyc_cnt    <= cyc_cnt + 1'b1;
      if (commit_valid_i) begin
        last_pc_r <= commit_pc_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      err_valid_o     <= 1'b0;
      err_first_src_o <= '0;
      err_all_src_o   <= '0;
      err_cycle_o     <= '0;
      err_last_pc_o   <= '0;
      err_timeout_o   <= 1'b0;
      err_count_o     <= '0;
    end else begin
      if (capture) begin
        // last_pc_r still holds the pre-update value, so a commit in the
        // error cycle itself is excluded from the capture.
        err_valid_o     <= 1'b1;
        err_first_src_o <= err_src_i;
        err_all_src_o   <= err_src_i;
        err_cycle_o     <= cyc_cnt;
        err_last_pc_o   <= last_pc_r;
        err_count_o     <= sat_inc8(err_count_o);
      end else if (clear) begin
        err_valid_o     <= 1'b0;
        err_first_src_o <= '0;
        err_all_src_o   <= '0;
        err_cycle_o     <= '0;
        err_last_pc_o   <= '0;
        err_timeout_o   <= 1'b0;
      end else if (state_q != ERR_IDLE) begin
        err_all_src_o <= err_all_src_o | err_src_i;
      end
      if (timeout_hit) begin
        err_timeout_o <= 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cpu_error_capture.sv
// Directed bench for cpu_error_capture: a vector table for the first
// capture/halt/clear sequence plus hand-written timeout, saturation and
// reset sequences.
module tb_cpu_error_capture;

  logic        clk;
  logic        rst_n;
  logic [8:0]  err_src_i;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic        halt_ack_i;
  logic        dbg_clear_i;
  logic        halt_req_o;
  logic        err_valid_o;
  logic [8:0]  err_first_src_o;
  logic [8:0]  err_all_src_o;
  logic [31:0] err_cycle_o;
  logic [31:0] err_last_pc_o;
  logic        err_timeout_o;
  logic [7:0]  err_count_o;
  logic [1:0]  state_o;

  cpu_error_capture dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .err_src_i       (err_src_i),
    .commit_valid_i  (commit_valid_i),
    .commit_pc_i     (commit_pc_i),
    .halt_ack_i      (halt_ack_i),
    .dbg_clear_i     (dbg_clear_i),
    .halt_req_o      (halt_req_o),
    .err_valid_o     (err_valid_o),
    .err_first_src_o (err_first_src_o),
    .err_all_src_o   (err_all_src_o),
    .err_cycle_o     (err_cycle_o),
    .err_last_pc_o   (err_last_pc_o),
    .err_timeout_o   (err_timeout_o),
    .err_count_o     (err_count_o),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  src;
    logic        cv;
    logic [31:0] pc;
    logic        ack;
    logic        clr;
    logic [1:0]  st;
    logic        req;
    logic        vld;
    logic [8:0]  first;
    logic [8:0]  all;
    logic [31:0] cyc;
    logic [31:0] lpc;
    logic [7:0]  cnt;
    logic        to;
  } vec_t;

  vec_t vecs[9];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;  // model of the DUT cycle counter for the current cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic req,
                            input logic vld, input logic [8:0] first, input logic [8:0] all,
                            input logic [31:0] cy, input logic [31:0] lpc,
                            input logic [7:0] cnt, input logic to);
    check({tag, ".state"},   64'(state_o),         64'(st));
    check({tag, ".req"},     64'(halt_req_o),      64'(req));
    check({tag, ".valid"},   64'(err_valid_o),     64'(vld));
    check({tag, ".first"},   64'(err_first_src_o), 64'(first));
    check({tag, ".all"},     64'(err_all_src_o),   64'(all));
    check({tag, ".cycle"},   64'(err_cycle_o),     64'(cy));
    check({tag, ".last_pc"}, 64'(err_last_pc_o),   64'(lpc));
    check({tag, ".count"},   64'(err_count_o),     64'(cnt));
    check({tag, ".timeout"}, 64'(err_timeout_o),   64'(to));
  endtask

  task automatic drive(input logic [8:0] src, input logic cv, input logic [31:0] pc,
                       input logic ack, input logic clr);
    err_src_i      = src;
    commit_valid_i = cv;
    commit_pc_i    = pc;
    halt_ack_i     = ack;
    dbg_clear_i    = clr;
  endtask

  // Advance one clock edge and sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) cyc++;
    else cyc = 0;
  endtask

  initial begin
    int ec;
    int exp_cnt;

    // Rows applied from cycle 19 onward; expected outputs are after the edge.
    vecs[0] = '{9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 9'h000, 9'h000, 32'd0,  32'h0,        8'd0, 1'b0};
    vecs[1] = '{9'h000, 1'b1, 32'h1c000010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'h000, 9'h000, 32'd0,  32'h0,        8'd0, 1'b0};
    vecs[2] = '{9'h020, 1'b1, 32'h1c000014, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h020, 9'h020, 32'd21, 32'h1c000010, 8'd1, 1'b0};
    vecs[3] = '{9'h100, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h020, 9'h120, 32'd21, 32'h1c000010, 8'd1, 1'b0};
    vecs[4] = '{9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 9'h020, 9'h120, 32'd21, 32'h1c000010, 8'd1, 1'b0};
    vecs[5] = '{9'h000, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h020, 9'h120, 32'd21, 32'h1c000010, 8'd1, 1'b0};
    vecs[6] = '{9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 9'h020, 9'h120, 32'd21, 32'h1c000010, 8'd1, 1'b0};
    vecs[7] = '{9'h001, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 9'h000, 9'h000, 32'd0,  32'h0,        8'd1, 1'b0};
    vecs[8] = '{9'h001, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 9'h001, 9'h001, 32'd27, 32'h1c000014, 8'd2, 1'b0};

    rst_n = 1'b0;
    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 9'h0, 9'h0, 32'd0, 32'h0, 8'd0, 1'b0);

    repeat (10) step();
    check_outs("idle10", 2'b00, 1'b0, 1'b0, 9'h0, 9'h0, 32'd0, 32'h0, 8'd0, 1'b0);
    while (cyc < 19) step();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].src, vecs[i].cv, vecs[i].pc, vecs[i].ack, vecs[i].clr);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].req, vecs[i].vld, vecs[i].first,
                 vecs[i].all, vecs[i].cyc, vecs[i].lpc, vecs[i].cnt, vecs[i].to);
    end

    // No ack: stays HALTING for 255 cycles, then times out.
    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (254) step();
    check_outs("to_wait", 2'b01, 1'b1, 1'b1, 9'h001, 9'h001, 32'd27, 32'h1c000014, 8'd2, 1'b0);
    step();
    check_outs("to_hit", 2'b10, 1'b1, 1'b1, 9'h001, 9'h001, 32'd27, 32'h1c000014, 8'd2, 1'b1);

    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    check_outs("clr2", 2'b00, 1'b0, 1'b0, 9'h0, 9'h0, 32'd0, 32'h0, 8'd2, 1'b0);

    // Ack arriving in the terminal cycle wins over the timeout.
    ec = cyc;
    drive(9'h004, 1'b1, 32'h1c000100, 1'b0, 1'b0);
    step();
    check_outs("ev3", 2'b01, 1'b1, 1'b1, 9'h004, 9'h004, 32'(ec), 32'h1c000014, 8'd3, 1'b0);
    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (254) step();
    check("ev3_wait.state", 64'(state_o), 64'(2'b01));
    drive(9'h000, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_outs("ack_at_to", 2'b10, 1'b1, 1'b1, 9'h004, 9'h004, 32'(ec), 32'h1c000014, 8'd3, 1'b0);
    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b1);
    step();

    // Event counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      drive(9'h010, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      drive(9'h000, 1'b0, 32'h0, 1'b1, 1'b0);
      step();
      drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b1);
      step();
      exp_cnt = (4 + i > 255) ? 255 : 4 + i;
      check($sformatf("sat%0d.count", i), 64'(err_count_o), 64'(exp_cnt));
    end
    check("sat.state", 64'(state_o), 64'(2'b00));

    // Reset in HALTING clears everything, including the counters.
    drive(9'h080, 1'b1, 32'h1c000200, 1'b0, 1'b0);
    step();
    check("pre_rst.state", 64'(state_o), 64'(2'b01));
    rst_n = 1'b0;
    drive(9'h000, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_outs("rst_halting", 2'b00, 1'b0, 1'b0, 9'h0, 9'h0, 32'd0, 32'h0, 8'd0, 1'b0);
    rst_n = 1'b1;
    drive(9'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (5) step();
    drive(9'h002, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_outs("post_rst", 2'b01, 1'b1, 1'b1, 9'h002, 9'h002, 32'd5, 32'h0, 8'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_error_capture.md
Name: cpu_error_capture

Overview:
- Consumer of the per-stage error flags (inst cache, data cache, IF, ID, launch, EX, MM, MEM, WB), sitting beside the sticky CPU error aggregator.
- Records the first error event: which sources fired, the cycle number and the last committed PC.
- Requests a pipeline halt through a req/ack handshake, then holds the capture for debug readout until it is explicitly cleared.

Parameters:
SRC_NUM, 9, number of error sources; bit order 0..8 = inst_cache, data_cache, if, id, launch, ex, mm, mem, wb
CNT_W, 32, width of the free-running cycle counter and the captured timestamp
PC_W, 32, PC width
ACK_TIMEOUT, 255, maximum cycles spent in HALTING waiting for halt_ack_i

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
err_src_i  input  SRC_NUM  per-source error level flags
commit_valid_i  input  1  an instruction commits this cycle
commit_pc_i  input  PC_W  PC of the committing instruction
halt_ack_i  input  1  pipeline confirms it is frozen
dbg_clear_i  input  1  debug request to release the capture and resume
halt_req_o  output  1  pipeline halt request
err_valid_o  output  1  capture registers hold a valid event
err_first_src_o  output  SRC_NUM  sources asserted in the first error cycle
err_all_src_o  output  SRC_NUM  OR of all sources seen since capture
err_cycle_o  output  CNT_W  counter value in the first error cycle
err_last_pc_o  output  PC_W  last PC committed strictly before the error cycle
err_timeout_o  output  1  HALTING exited by timeout, not by ack
err_count_o  output  8  number of captured events, saturating
state_o  output  2  FSM state: 00 IDLE, 01 HALTING, 10 HALTED

Behaviour:
- Reset: all outputs and internal registers are 0. Reset has priority over every other input, including mid-HALTING.
- cyc_cnt: increments every cycle and wraps 2^CNT_W-1 -> 0.
- last_pc_r: loads commit_pc_i whenever commit_valid_i is 1, in every state.
- All outputs are registered. halt_req_o is 1 exactly when state is HALTING or HALTED.
- IDLE:
  - If err_src_i != 0, the same edge:
    - err_first_src_o <= err_src_i and err_all_src_o <= err_src_i
    - err_cycle_o <= cyc_cnt (the current value)
    - err_last_pc_o <= last_pc_r (the pre-update value; a commit in the error cycle is excluded)
    - err_valid_o <= 1; err_count_o increments unless it is already 255
    - state -> HALTING, so halt_req_o is 1 in the next cycle (1-cycle latency).
  - dbg_clear_i is ignored in IDLE.
- HALTING:
  - err_all_src_o |= err_src_i every cycle.
  - to_cnt increments from 0 each cycle.
  - halt_ack_i = 1 -> HALTED.
  - Otherwise, if to_cnt reaches ACK_TIMEOUT-1, -> HALTED with err_timeout_o <= 1.
  - An ack arriving in the same cycle as the timeout counts as an ack: err_timeout_o stays 0.
  - dbg_clear_i is ignored. New errors never re-capture first/cycle/pc.
- HALTED:
  - err_all_src_o keeps accumulating.
  - dbg_clear_i = 1 -> IDLE, clearing err_valid_o, err_first_src_o, err_all_src_o, err_cycle_o, err_last_pc_o, err_timeout_o and to_cnt.
  - err_count_o and cyc_cnt are not cleared.
  - dbg_clear_i and err_src_i asserted together: clear wins. An error that is still asserted is captured in the following IDLE cycle as a new event.
- halt_ack_i outside HALTING is ignored.

Decomposition:
- Shared package (DefineModuleBus.h):
  - state encodings ERR_IDLE / ERR_HALTING / ERR_HALTED
  - source bit-index constants
  - `RstEnable reused for rst_n comparison
- One sub-module is natural: err_timeout_counter, a loadable/clearable counter with a terminal flag, used for to_cnt.
- The remainder (FSM plus capture registers) stays flat.

Test Plan:
- Reset, then run 10 idle cycles with no errors -> all outputs 0, state_o = 00, cyc_cnt = 10.
- Commit PC 0x1c000010 at cycle 20; at cycle 21 err_src_i = 0x020 (ex) together with a commit of 0x1c000014 -> err_first_src_o = 0x020, err_cycle_o = 21, err_last_pc_o = 0x1c000010, halt_req_o = 1 from cycle 22, err_count_o = 1.
- In HALTING, pulse err_src_i = 0x100 (wb), then ack after 3 cycles -> err_all_src_o = 0x120, err_first_src_o unchanged, state_o = 10, err_timeout_o = 0.
- Error with no ack -> after 255 HALTING cycles state_o = 10 and err_timeout_o = 1; ack and timeout in the same cycle -> err_timeout_o = 0.
- In HALTED, assert dbg_clear_i with err_src_i = 0x001 held -> next cycle IDLE with captures cleared; the cycle after, a new capture with err_first_src_o = 0x001 and err_count_o = 2.
- Generate 260 error/clear events -> err_count_o saturates at 255. Assert reset while in HALTING -> all outputs 0 on the next edge.
